// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, bubble word, PC step.
package if_stage_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HELD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter: holds on !i_en, otherwise loads the aligned redirect target or steps by 4.
import if_stage_pkg::*;

module if_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [31:0] i_dest,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // 32-bit add wraps 0xFFFF_FFFC -> 0 naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pc <= RESET_PC;
        else if (i_en)
            r_pc <= i_load ? align_word(i_dest) : r_pc + PC_INC;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC, variable-latency imem handshake, IF/ID register, stall/redirect handling.
// Define IF_PERF_CNT_EN to add fetched-instruction and stall-cycle counters.
import if_stage_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_PC_WriteEnable,
    input  logic        i_IFIDWriteEnable,
    input  logic        i_Branch,
    input  logic [31:0] i_BranchDest,
    input  logic        i_Jump,
    input  logic [31:0] i_JumpDest,
    output logic        o_IMem_Req,
    output logic [31:0] o_IMem_Addr,
    input  logic        i_IMem_Ready,
    input  logic [31:0] i_IMem_Data,
    output logic [31:0] o_IFID_Instruction,
    output logic [31:0] o_IFID_PC,
    output logic        o_IFID_JFlush,
    output logic        o_Fetch_Stall
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] o_Perf_Fetched,
    output logic [31:0] o_Perf_StallCycles
`endif
);

    fetch_state_t r_state;
    logic         r_req;
    logic [31:0]  r_hold;
    logic [31:0]  r_redir;
    logic [31:0]  r_ifid_instr;
    logic [31:0]  r_ifid_pc;
    logic         r_ifid_jflush;

    logic         w_redirect;
    logic [31:0]  w_dest;
    logic [31:0]  w_pc;
    logic         w_pc_en;
    logic         w_pc_load;
    logic [31:0]  w_pc_dest;

    assign w_redirect = i_Branch | i_Jump;
    assign w_dest     = align_word(i_Jump ? i_JumpDest : i_BranchDest);

    // PC update decision; in S_DROP the PC keeps the in-flight address until Ready
    always_comb begin
        w_pc_en   = 1'b0;
        w_pc_load = 1'b0;
        w_pc_dest = w_dest;
        case (r_state)
            S_RUN: begin
                if (i_IMem_Ready) begin
                    if (w_redirect) begin
                        w_pc_en   = 1'b1;
                        w_pc_load = 1'b1;
                    end else if (i_IFIDWriteEnable && i_PC_WriteEnable) begin
                        w_pc_en = 1'b1;
                    end
                end
            end
            S_HELD: begin
                if (w_redirect) begin
                    w_pc_en   = 1'b1;
                    w_pc_load = 1'b1;
                end else if (i_IFIDWriteEnable) begin
                    w_pc_en = 1'b1;
                end
            end
            S_DROP: begin
                if (i_IMem_Ready) begin
                    w_pc_en   = 1'b1;
                    w_pc_load = 1'b1;
                    if (!w_redirect)
                        w_pc_dest = r_redir;
                end
            end
            default: ;
        endcase
    end

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .i_clk   (i_Clock),
        .i_rst_n (i_Reset),
        .i_en    (w_pc_en),
        .i_load  (w_pc_load),
        .i_dest  (w_pc_dest),
        .o_pc    (w_pc)
    );

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state       <= S_BOOT;
            r_req         <= 1'b0;
            r_hold        <= '0;
            r_redir       <= '0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc     <= '0;
            r_ifid_jflush <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_req   <= 1'b1;
                end
                S_RUN: begin
                    if (i_IMem_Ready) begin
                        if (w_redirect) begin
                            r_ifid_instr  <= NOP_INSTR;
                            r_ifid_jflush <= 1'b1;
                        end else if (i_IFIDWriteEnable) begin
                            r_ifid_instr  <= i_IMem_Data;
                            r_ifid_pc     <= w_pc;
                            r_ifid_jflush <= 1'b0;
                        end else begin
                            r_hold  <= i_IMem_Data;
                            r_state <= S_HELD;
                            r_req   <= 1'b0;
                        end
                    end else if (w_redirect) begin
                        // request cannot be withdrawn; remember where to go once it completes
                        r_redir       <= w_dest;
                        r_ifid_instr  <= NOP_INSTR;
                        r_ifid_jflush <= 1'b1;
                        r_state       <= S_DROP;
                    end else if (i_IFIDWriteEnable) begin
                        r_ifid_instr  <= NOP_INSTR;
                        r_ifid_jflush <= 1'b0;
                    end
                end
                S_HELD: begin
                    if (w_redirect) begin
                        r_ifid_instr  <= NOP_INSTR;
                        r_ifid_jflush <= 1'b1;
                        r_state       <= S_RUN;
                        r_req         <= 1'b1;
                    end else if (i_IFIDWriteEnable) begin
                        r_ifid_instr  <= r_hold;
                        r_ifid_pc     <= w_pc;
                        r_ifid_jflush <= 1'b0;
                        r_state       <= S_RUN;
                        r_req         <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (w_redirect)
                        r_redir <= w_dest;
                    if (i_IFIDWriteEnable) begin
                        r_ifid_instr  <= NOP_INSTR;
                        r_ifid_jflush <= 1'b1;
                    end
                    if (i_IMem_Ready)
                        r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_IMem_Req         = r_req;
    assign o_IMem_Addr        = w_pc;
    assign o_IFID_Instruction = r_ifid_instr;
    assign o_IFID_PC          = r_ifid_pc;
    assign o_IFID_JFlush      = r_ifid_jflush;
    assign o_Fetch_Stall      = ((r_state == S_RUN) && !i_IMem_Ready) ||
                                (r_state == S_HELD) || (r_state == S_DROP);

`ifdef IF_PERF_CNT_EN
    logic        w_fetch_load;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    assign w_fetch_load = !w_redirect && i_IFIDWriteEnable &&
                          (((r_state == S_RUN) && i_IMem_Ready) || (r_state == S_HELD));

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_fetch_load)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (o_Fetch_Stall)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_Perf_Fetched     = r_perf_fetched;
    assign o_Perf_StallCycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage: per-cycle expectations are queued by the
// stimulus and popped by an independent negedge monitor.
module tb_if_fetch_stage;

    typedef struct {
        int          cyc;
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic [31:0] instr;
        logic        chk_pc;
        logic [31:0] pc;
        logic        jf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_we = 1'b1, ifid_we = 1'b1;
    logic        br = 1'b0, jp = 1'b0;
    logic [31:0] br_dst = '0, jp_dst = '0;
    logic        req, ready = 1'b0, jflush, stall;
    logic [31:0] addr, mem_data, ifid_instr, ifid_pc;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from the address so every fetch is distinguishable
    function automatic logic [31:0] D(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign mem_data = D(addr);

    if_fetch_stage dut (
        .i_Clock            (clk),
        .i_Reset            (rst_n),
        .i_PC_WriteEnable   (pc_we),
        .i_IFIDWriteEnable  (ifid_we),
        .i_Branch           (br),
        .i_BranchDest       (br_dst),
        .i_Jump             (jp),
        .i_JumpDest         (jp_dst),
        .o_IMem_Req         (req),
        .o_IMem_Addr        (addr),
        .i_IMem_Ready       (ready),
        .i_IMem_Data        (mem_data),
        .o_IFID_Instruction (ifid_instr),
        .o_IFID_PC          (ifid_pc),
        .o_IFID_JFlush      (jflush),
        .o_Fetch_Stall      (stall)
    );

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("req", e.cyc, {31'd0, req}, {31'd0, e.req});
            if (e.req) chk("addr", e.cyc, addr, e.addr);
            chk("stall", e.cyc, {31'd0, stall}, {31'd0, e.stall});
            chk("ifid_instr", e.cyc, ifid_instr, e.instr);
            if (e.chk_pc) chk("ifid_pc", e.cyc, ifid_pc, e.pc);
            chk("jflush", e.cyc, {31'd0, jflush}, {31'd0, e.jf});
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic iwe, input logic pwe,
                        input logic b, input logic [31:0] bd, input logic j, input logic [31:0] jd,
                        input logic ereq, input logic [31:0] eaddr, input logic estall,
                        input logic [31:0] einstr, input logic echk, input logic [31:0] epc,
                        input logic ejf);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; ready = rdy; ifid_we = iwe; pc_we = pwe;
        br = b; br_dst = bd; jp = j; jp_dst = jd;
        e.cyc = cyc; e.req = ereq; e.addr = eaddr; e.stall = estall;
        e.instr = einstr; e.chk_pc = echk; e.pc = epc; e.jf = ejf;
        q.push_back(e);
        cyc++;
    endtask

    initial begin
        //   rst rdy iwe pwe br  bdst        jp  jdst           req addr           stl instr                  chk pc            jf
        step(0, 1, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          0, 32'h0,                 1, 32'h0,          0); // in reset
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          0, 32'h0,                 1, 32'h0,          0); // S_BOOT
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h0,          0, 32'h0,                 1, 32'h0,          0);
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h4,          0, D(32'h0),              1, 32'h0,          0);
        step(1, 0, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h8,          1, D(32'h4),              1, 32'h4,          0); // miss x3 at 8
        step(1, 0, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h8,          1, 32'h0,                 0, 32'h0,          0);
        step(1, 0, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h8,          1, 32'h0,                 0, 32'h0,          0);
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h8,          0, 32'h0,                 0, 32'h0,          0);
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'hC,          0, D(32'h8),              1, 32'h8,          0);
        step(1, 1, 0, 1, 0, 32'h0,      0, 32'h0,          1, 32'h10,         0, D(32'hC),              1, 32'hC,          0); // IF/ID stall at 0x10
        step(1, 1, 0, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          1, D(32'hC),              1, 32'hC,          0); // S_HELD
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          1, D(32'hC),              1, 32'hC,          0); // release
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h14,         0, D(32'h10),             1, 32'h10,         0);
        step(1, 1, 1, 1, 1, 32'h40,     0, 32'h0,          1, 32'h18,         0, D(32'h14),             1, 32'h14,         0); // branch
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h40,         0, 32'h0,                 0, 32'h0,          1);
        step(1, 1, 1, 1, 0, 32'h0,      1, 32'h20,         1, 32'h44,         0, D(32'h40),             1, 32'h40,         0); // jump to 0x20
        step(1, 0, 1, 1, 0, 32'h0,      1, 32'h80,         1, 32'h20,         1, 32'h0,                 0, 32'h0,          1); // jump while miss
        step(1, 0, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h20,         1, 32'h0,                 0, 32'h0,          1); // S_DROP
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h20,         1, 32'h0,                 0, 32'h0,          1);
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h80,         0, 32'h0,                 0, 32'h0,          1);
        step(1, 0, 1, 1, 1, 32'h100,    0, 32'h0,          1, 32'h84,         1, D(32'h80),             1, 32'h80,         0); // branch while miss
        step(1, 0, 1, 1, 0, 32'h0,      1, 32'h200,        1, 32'h84,         1, 32'h0,                 0, 32'h0,          1); // overwrite redir
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h84,         1, 32'h0,                 0, 32'h0,          1);
        step(1, 0, 1, 1, 0, 32'h0,      1, 32'h300,        1, 32'h200,        1, 32'h0,                 0, 32'h0,          1); // last redirect won
        step(0, 0, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          0, 32'h0,                 1, 32'h0,          0); // reset in S_DROP
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h0,          0, 32'h0,                 1, 32'h0,          0); // S_BOOT
        step(1, 1, 1, 1, 0, 32'h0,      1, 32'hFFFF_FFFF,  1, 32'h0,          0, 32'h0,                 1, 32'h0,          0); // unaligned dest
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,                 0, 32'h0,          1);
        step(1, 1, 1, 0, 0, 32'h0,      0, 32'h0,          1, 32'h0,          0, D(32'hFFFF_FFFC),      1, 32'hFFFF_FFFC,  0); // wrapped; PC hold
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h0,          0, D(32'h0),              1, 32'h0,          0);
        step(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,          1, 32'h4,          0, D(32'h0),              1, 32'h0,          0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
